// File: rtl/inv_cipher_round_if.sv
// Block bus between inverse cipher round stages.
// Handshake: tx_en is a valid-only strobe. When tx_en is 1 on a rising clock
// edge, state and round_key are one block transfer. There is no ready signal,
// so the sink accepts a block on every edge. While tx_en is 0, state and
// round_key carry no meaning.
interface inv_cipher_round_if;
  logic         tx_en;
  logic [127:0] state;
  logic [127:0] round_key;

  modport master (output tx_en, output state, output round_key);
  modport slave  (input  tx_en, input  state, input  round_key);
endinterface

// File: rtl/inv_cipher_round.sv
// One pipelined AES-128 inverse cipher round.
// The data path is InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns,
// with one register per step. The block enters at the slave bus and leaves four
// edges later on the master bus.
// The key path derives k[ROUND] from k[ROUND+1] by inverse key expansion.
// It delays k[ROUND] so that the key reaches the output together with the
// state that used it.
module inv_cipher_round #(
  parameter int ROUND = 0
) (
  input  logic              clock,
  input  logic              reset,
  inv_cipher_round_if.slave  in_bus,
  inv_cipher_round_if.master out_bus
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Each table is stored with entry 0 in the top byte.
  // Entry x therefore ends at bit 8*(255-x)+7, which is {~x, 3'b111}.
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sub_byte(input logic [7:0] x);
    return INV_SBOX_TBL[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] rcon_for(input int idx);
    logic [7:0] rc;
    case (idx)
      1:       rc = 8'h01;
      2:       rc = 8'h02;
      3:       rc = 8'h04;
      4:       rc = 8'h08;
      5:       rc = 8'h10;
      6:       rc = 8'h20;
      7:       rc = 8'h40;
      8:       rc = 8'h80;
      9:       rc = 8'h1b;
      10:      rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  localparam logic [7:0] RCON = rcon_for(ROUND + 1);

  // Row r rotates right by r bytes.
  // Output order is s0,s13,s10,s7, s4,s1,s14,s11, s8,s5,s2,s15, s12,s9,s6,s3.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],   s[47:40],   s[71:64],
            s[95:88],   s[119:112], s[15:8],    s[39:32],
            s[63:56],   s[87:80],   s[111:104], s[7:0],
            s[31:24],   s[55:48],   s[79:72],   s[103:96]};
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sub_byte(s[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
    return r;
  endfunction

  // The input key {w4,w5,w6,w7} is turned into the preceding key {w0,w1,w2,w3}.
  function automatic logic [127:0] inv_expand(input logic [127:0] k);
    logic [31:0] w4, w5, w6, w7, w0, w1, w2, w3, rot, sub;
    {w4, w5, w6, w7} = k;
    w3  = w7 ^ w6;
    w2  = w6 ^ w5;
    w1  = w5 ^ w4;
    rot = {w3[23:0], w3[31:24]};
    sub = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
           sub_byte(rot[15:8]),  sub_byte(rot[7:0])};
    w0  = w4 ^ sub ^ {RCON, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  logic         s1_v, s2_v, s3_v, s4_v;
  logic [127:0] s1_state, s2_state, s3_state, s4_state;
  logic [127:0] s1_key, s2_key, s3_key, s4_key;
  logic [127:0] shift_nxt, key_nxt, sub_nxt, ark_nxt, mix_nxt;

  // Combinational work of each stage, taken from that stage's input register.
  always_comb begin
    shift_nxt = inv_shift_rows(in_bus.state);
    key_nxt   = inv_expand(in_bus.round_key);
    sub_nxt   = inv_sub_bytes(s1_state);
    ark_nxt   = s2_state ^ s2_key;
    mix_nxt   = s3_state;
    if (ROUND != 0) mix_nxt = inv_mix_columns(s3_state);
  end

  // Pipeline registers. Valid advances one stage per edge. Data and key
  // registers load zero behind an invalid slot, so don't-care inputs never
  // reach the outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_v <= 1'b0; s1_state <= '0; s1_key <= '0;
      s2_v <= 1'b0; s2_state <= '0; s2_key <= '0;
      s3_v <= 1'b0; s3_state <= '0; s3_key <= '0;
      s4_v <= 1'b0; s4_state <= '0; s4_key <= '0;
    end else begin
      s1_v     <= in_bus.tx_en;
      s1_state <= in_bus.tx_en ? shift_nxt : '0;
      s1_key   <= in_bus.tx_en ? key_nxt : '0;
      s2_v     <= s1_v;
      s2_state <= s1_v ? sub_nxt : '0;
      s2_key   <= s1_v ? s1_key : '0;
      s3_v     <= s2_v;
      s3_state <= s2_v ? ark_nxt : '0;
      s3_key   <= s2_v ? s2_key : '0;
      s4_v     <= s3_v;
      s4_state <= s3_v ? mix_nxt : '0;
      s4_key   <= s3_v ? s3_key : '0;
    end
  end

  assign out_bus.tx_en     = s4_v;
  assign out_bus.state     = s4_state;
  assign out_bus.round_key = s4_key;

endmodule
